// File: rtl/pu_config_regs.sv
// AXI4-Lite register bank feeding the protection unit checker: CTRL, STATUS, VADDR and POLICY[].
// Optional macro PU_CFG_LOCK_EN adds a write-once LOCK register at 0x0C that freezes CTRL/POLICY.
module pu_config_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int NUM_POLICY         = 4,
    parameter int ID_WIDTH           = 1
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       ctrl_o,
    output logic [32*NUM_POLICY-1:0]            policy_o,
    input  logic                                viol_i,
    input  logic [31:0]                         viol_addr_i,
    input  logic [ID_WIDTH-1:0]                 viol_id_i,
    output logic                                irq_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {A_CTRL, A_STATUS, A_VADDR, A_LOCK, A_POLICY, A_BAD} reg_sel_e;
    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    // Word index is byte address [6:2]; the upper half of the map (0x40+) holds the policy words.
    function automatic reg_sel_e decode(input logic [4:0] word);
        reg_sel_e sel;
        sel = A_BAD;
        if (word[4]) begin
            if ({1'b0, word[3:0]} < 5'(NUM_POLICY)) sel = A_POLICY;
        end else begin
            case (word[3:0])
                4'h0:    sel = A_CTRL;
                4'h1:    sel = A_STATUS;
                4'h2:    sel = A_VADDR;
`ifdef PU_CFG_LOCK_EN
                4'h3:    sel = A_LOCK;
`endif
                default: sel = A_BAD;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] cur, input logic [31:0] nxt,
                                               input logic [3:0] strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? nxt[8*b +: 8] : cur[8*b +: 8];
        return res;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    w_state_e                        w_state;
    r_state_e                        r_state;
    logic                            aw_full, w_full;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr_q;
    logic [31:0]                     wdata_q;
    logic [3:0]                      wstrb_q;
    logic                            aw_hs, w_hs, ar_hs, do_write, wr_err, status_clr;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr;
    logic [31:0]                     wr_data;
    logic [3:0]                      wr_strb;
    reg_sel_e                        wr_sel, rd_sel;
    logic [31:0]                     rd_data;
    logic [1:0]                      rd_resp;

    logic [31:0]                     ctrl_q;
    logic [31:0]                     policy_q [NUM_POLICY];
    logic                            viol_flag_q;
    logic [7:0]                      viol_cnt_q;
    logic [ID_WIDTH-1:0]             viol_id_q;
    logic [31:0]                     viol_addr_q;
    logic                            lock_q;
    logic                            unused_ok;

    assign aw_hs = s00_axi_awvalid & s00_axi_awready;
    assign w_hs  = s00_axi_wvalid & s00_axi_wready;
    assign ar_hs = s00_axi_arvalid & s00_axi_arready;

    // The commit uses whichever of the latched or live AW/W beats is present this cycle.
    assign wr_addr  = aw_full ? awaddr_q : s00_axi_awaddr;
    assign wr_data  = w_full ? wdata_q : s00_axi_wdata;
    assign wr_strb  = w_full ? wstrb_q : s00_axi_wstrb;
    assign do_write = (w_state == W_IDLE) && (aw_full || aw_hs) && (w_full || w_hs);
    assign wr_sel   = decode(wr_addr[6:2]);
    assign wr_err   = (wr_sel == A_BAD) || (lock_q && (wr_sel == A_CTRL || wr_sel == A_POLICY));
    assign status_clr = do_write && (wr_sel == A_STATUS) && wr_strb[0] && wr_data[0];

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, wr_addr[1:0], s00_axi_araddr[1:0]};

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            w_state         <= W_IDLE;
            aw_full         <= 1'b0;
            w_full          <= 1'b0;
            awaddr_q        <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (do_write) begin
                        aw_full         <= 1'b0;
                        w_full          <= 1'b0;
                        s00_axi_awready <= 1'b0;
                        s00_axi_wready  <= 1'b0;
                        s00_axi_bvalid  <= 1'b1;
                        s00_axi_bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
                        w_state         <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_full  <= 1'b1;
                            awaddr_q <= s00_axi_awaddr;
                        end
                        if (w_hs) begin
                            w_full  <= 1'b1;
                            wdata_q <= s00_axi_wdata;
                            wstrb_q <= s00_axi_wstrb;
                        end
                        s00_axi_awready <= !(aw_full || aw_hs);
                        s00_axi_wready  <= !(w_full || w_hs);
                    end
                end
                W_RESP: begin
                    if (s00_axi_bready) begin
                        s00_axi_bvalid  <= 1'b0;
                        s00_axi_awready <= 1'b1;
                        s00_axi_wready  <= 1'b1;
                        w_state         <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ctrl_q <= '0;
            for (int i = 0; i < NUM_POLICY; i++) policy_q[i] <= '0;
        end else if (do_write && !wr_err) begin
            if (wr_sel == A_CTRL) ctrl_q <= apply_strb(ctrl_q, wr_data, wr_strb);
            for (int i = 0; i < NUM_POLICY; i++) begin
                if (wr_sel == A_POLICY && wr_addr[5:2] == 4'(i))
                    policy_q[i] <= apply_strb(policy_q[i], wr_data, wr_strb);
            end
        end
    end

`ifdef PU_CFG_LOCK_EN
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) lock_q <= 1'b0;
        else if (do_write && wr_sel == A_LOCK && wr_strb[0] && wr_data[0]) lock_q <= 1'b1;
    end
`else
    assign lock_q = 1'b0;
`endif

    // A violation arriving with a W1C clear wins and restarts the capture at count 1.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            viol_flag_q <= 1'b0;
            viol_cnt_q  <= '0;
            viol_id_q   <= '0;
            viol_addr_q <= '0;
            irq_o       <= 1'b0;
        end else begin
            if (viol_i) begin
                viol_cnt_q <= status_clr ? 8'd1 : sat_inc(viol_cnt_q);
                if (status_clr || !viol_flag_q) begin
                    viol_flag_q <= 1'b1;
                    viol_addr_q <= viol_addr_i;
                    viol_id_q   <= viol_id_i;
                end
            end else if (status_clr) begin
                viol_flag_q <= 1'b0;
                viol_cnt_q  <= '0;
                viol_id_q   <= '0;
            end
            irq_o <= viol_flag_q & ctrl_q[1];
        end
    end

    assign rd_sel = decode(s00_axi_araddr[6:2]);

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rd_sel)
            A_CTRL:   rd_data = ctrl_q;
            A_STATUS: rd_data = {8'h00, 8'(viol_id_q), viol_cnt_q, 7'h00, viol_flag_q};
            A_VADDR:  rd_data = viol_addr_q;
            A_LOCK:   rd_data = {31'h0, lock_q};
            A_POLICY: begin
                for (int i = 0; i < NUM_POLICY; i++)
                    if (s00_axi_araddr[5:2] == 4'(i)) rd_data = policy_q[i];
            end
            default:  rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_state         <= R_IDLE;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            s00_axi_rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        s00_axi_rdata   <= rd_data;
                        s00_axi_rresp   <= rd_resp;
                        s00_axi_rvalid  <= 1'b1;
                        s00_axi_arready <= 1'b0;
                        r_state         <= R_DATA;
                    end else begin
                        s00_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s00_axi_rready) begin
                        s00_axi_rvalid  <= 1'b0;
                        s00_axi_arready <= 1'b1;
                        r_state         <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign ctrl_o = ctrl_q;
    for (genvar g = 0; g < NUM_POLICY; g++) begin : g_policy
        assign policy_o[32*g +: 32] = policy_q[g];
    end

endmodule

// File: tb/tb_pu_config_regs.sv
// Scoreboard bench for pu_config_regs: a register-map model predicts B/R responses and sideband outputs.
`timescale 1ns/1ps
module tb_pu_config_regs;
    localparam int NP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
    logic [31:0] ctrl_o;
    logic [32*NP-1:0] policy_o;
    logic        viol = 0;
    logic [31:0] viol_addr = '0;
    logic [0:0]  viol_id = '0;
    logic        irq;

    always #5 clk = ~clk;

    pu_config_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7), .NUM_POLICY(NP), .ID_WIDTH(1)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .ctrl_o(ctrl_o), .policy_o(policy_o),
        .viol_i(viol), .viol_addr_i(viol_addr), .viol_id_i(viol_id), .irq_o(irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic [31:0] data; logic [1:0] resp; } rd_exp_t;
    logic [1:0] b_q [$];
    rd_exp_t    r_q [$];

    // Reference model of the register map.
    logic [31:0] m_ctrl, m_vaddr;
    logic [31:0] m_pol [NP];
    bit          m_flag, m_lock;
    int          m_count, m_id;

    logic [6:0] addrs [13] = '{7'h00, 7'h04, 7'h08, 7'h0C, 7'h10, 7'h20, 7'h3C,
                               7'h40, 7'h44, 7'h48, 7'h4C, 7'h50, 7'h7C};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_ctrl = 0; m_vaddr = 0; m_flag = 0; m_lock = 0; m_count = 0; m_id = 0;
        for (int i = 0; i < NP; i++) m_pol[i] = 0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic int pol_index(input logic [6:0] a);
        if (a >= 7'h40 && ((int'(a) - 'h40) / 4) < NP) return (int'(a) - 'h40) / 4;
        return -1;
    endfunction

    function automatic logic [1:0] m_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
        int pi;
        pi = pol_index(a);
        if (a == 7'h00) begin
            if (m_lock) return 2'b10;
            m_ctrl = merge(m_ctrl, d, s);
            return 2'b00;
        end
        if (a == 7'h04) begin
            if (s[0] && d[0]) begin m_flag = 0; m_count = 0; m_id = 0; end
            return 2'b00;
        end
        if (a == 7'h08) return 2'b00;
`ifdef PU_CFG_LOCK_EN
        if (a == 7'h0C) begin
            if (s[0] && d[0]) m_lock = 1;
            return 2'b00;
        end
`endif
        if (pi >= 0) begin
            if (m_lock) return 2'b10;
            m_pol[pi] = merge(m_pol[pi], d, s);
            return 2'b00;
        end
        return 2'b10;
    endfunction

    function automatic void m_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] r);
        int pi;
        pi = pol_index(a);
        d = 0; r = 2'b00;
        if (a == 7'h00) d = m_ctrl;
        else if (a == 7'h04) d = {8'h00, 8'(m_id), 8'(m_count), 7'h00, m_flag};
        else if (a == 7'h08) d = m_vaddr;
`ifdef PU_CFG_LOCK_EN
        else if (a == 7'h0C) d = {31'h0, m_lock};
`endif
        else if (pi >= 0) d = m_pol[pi];
        else r = 2'b10;
    endfunction

    function automatic void m_viol(input logic [31:0] a, input int id);
        m_count = (m_count < 255) ? m_count + 1 : 255;
        if (!m_flag) begin m_flag = 1; m_vaddr = a; m_id = id; end
    endfunction

    // Monitor: pops the scoreboard whenever a response handshake is about to complete.
    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            if (b_q.size() == 0) check("unexpected_b", 32'(bvalid), 32'd0);
            else check("bresp", 32'(bresp), 32'(b_q.pop_front()));
        end
        if (rst_n && rvalid && rready) begin
            if (r_q.size() == 0) check("unexpected_r", 32'(rvalid), 32'd0);
            else begin
                rd_exp_t e;
                e = r_q.pop_front();
                check("rdata", rdata, e.data);
                check("rresp", 32'(rresp), 32'(e.resp));
            end
        end
    end

    // w_lead > 0: W offered that many cycles before AW; < 0: AW first; 0: together.
    task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int w_lead, input int b_hold,
                             input bit coincide, input logic [31:0] va, input int vid);
        int  aw_at, w_at, t;
        bit  aw_done, w_done, aw_f, w_f;
        b_q.push_back(m_write(a, d, s));
        if (coincide) m_viol(va, vid);
        aw_at = (w_lead > 0) ? w_lead : 0;
        w_at  = (w_lead < 0) ? -w_lead : 0;
        awaddr = a; wdata = d; wstrb = s;
        aw_done = 0; w_done = 0; t = 0;
        while (!(aw_done && w_done) && t < 40) begin
            if (!aw_done && t >= aw_at) awvalid = 1;
            if (!w_done && t >= w_at) wvalid = 1;
            if (coincide && t == 0) begin viol = 1; viol_addr = va; viol_id = 1'(vid); end
            @(negedge clk);
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(posedge clk); #1;
            viol = 0;
            if (aw_f) begin awvalid = 0; aw_done = 1; end
            if (w_f)  begin wvalid = 0; w_done = 1; end
            t++;
        end
        awvalid = 0; wvalid = 0;
        if (!(aw_done && w_done)) check("aw_w_handshake_timeout", 32'd0, 32'd1);
        t = 0;
        while (!bvalid && t < 20) begin @(posedge clk); #1; t++; end
        if (!bvalid) check("bvalid_timeout", 32'd0, 32'd1);
        for (int i = 0; i < b_hold; i++) begin
            @(posedge clk); #1;
            check("bvalid_hold", 32'(bvalid), 32'd1);
        end
        bready = 1;
        @(negedge clk);
        @(posedge clk); #1;
        bready = 0;
        check("bvalid_drop", 32'(bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [6:0] a, input int r_hold);
        rd_exp_t e;
        int t;
        bit fired;
        m_read(a, e.data, e.resp);
        r_q.push_back(e);
        araddr = a; arvalid = 1; fired = 0; t = 0;
        while (!fired && t < 20) begin
            @(negedge clk); fired = arready;
            @(posedge clk); #1; t++;
        end
        arvalid = 0;
        if (!fired) check("ar_timeout", 32'd0, 32'd1);
        check("r_latency", 32'(rvalid), 32'd1);
        for (int i = 0; i < r_hold; i++) begin @(posedge clk); #1; end
        rready = 1;
        @(negedge clk);
        @(posedge clk); #1;
        rready = 0;
    endtask

    task automatic pulse_viol(input logic [31:0] a, input int id);
        m_viol(a, id);
        viol = 1; viol_addr = a; viol_id = 1'(id);
        @(posedge clk); #1;
        viol = 0;
    endtask

    task automatic check_side();
        @(posedge clk); #1;
        check("ctrl_o", ctrl_o, m_ctrl);
        for (int i = 0; i < NP; i++) check("policy_o", policy_o[32*i +: 32], m_pol[i]);
        check("irq_o", 32'(irq), 32'(m_flag & m_ctrl[1]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        bit aw_f, w_f;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 0);
        check("rst_wready", 32'(wready), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_bresp", 32'(bresp), 0);
        check("rst_rresp", 32'(rresp), 0);
        check("rst_rdata", rdata, 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_ctrl", ctrl_o, 0);
        for (int i = 0; i < NP; i++) check("rst_policy", policy_o[32*i +: 32], 0);
        rst_n = 1;
        @(posedge clk); #1;

        axi_write(7'h00, 32'hF0F0F0F0, 4'hF, 0, 0, 0, 0, 0);
        axi_read(7'h00, 0);
        check_side();

        axi_write(7'h40, 32'h0000002C, 4'b0001, -1, 1, 0, 0, 0);
        axi_read(7'h40, 1);
        check_side();
        axi_write(7'h40, 32'hFFFFFFFF, 4'b0100, 2, 0, 0, 0, 0);
        axi_read(7'h40, 0);

        axi_write(7'h44, 32'hA5A5_1234, 4'hF, 3, 5, 0, 0, 0);
        repeat (3) begin @(posedge clk); #1; check("single_bvalid", 32'(bvalid), 0); end
        axi_read(7'h44, 0);
        check_side();

        axi_write(7'h00, 32'h0000_0002, 4'hF, 0, 0, 0, 0, 0);
        pulse_viol(32'h4000_1000, 1);
        pulse_viol(32'h5000_0000, 0);
        check_side();
        axi_read(7'h04, 0);
        axi_read(7'h08, 0);
        axi_write(7'h04, 32'h1, 4'hF, 0, 0, 0, 0, 0);
        check("irq_after_clear", 32'(irq), 0);
        axi_read(7'h04, 0);
        check_side();

        axi_read(7'h20, 0);
        axi_write(7'h7C, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0);
        axi_read(7'h00, 0);
        axi_read(7'h40, 0);
        axi_read(7'h44, 0);
        check_side();

        pulse_viol(32'h1111_0000, 0);
        axi_write(7'h04, 32'h1, 4'h1, 0, 0, 1, 32'h2222_0000, 1);
        axi_read(7'h04, 0);
        axi_read(7'h08, 0);
        check_side();

        axi_write(7'h04, 32'h1, 4'h1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) pulse_viol(32'h3000_0000 + i, i % 2);
        axi_read(7'h04, 0);
        axi_read(7'h08, 0);

        for (int n = 0; n < 80; n++) begin
            int op;
            logic [6:0] a;
            op = $urandom_range(0, 9);
            a = addrs[$urandom_range(0, 12)];
            if (op < 4)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                          $urandom_range(0, 3), 0, 0, 0);
            else if (op < 8)
                axi_read(a, $urandom_range(0, 2));
            else
                pulse_viol($urandom, $urandom_range(0, 1));
            check_side();
        end

        axi_write(7'h0C, 32'h1, 4'hF, 0, 0, 0, 0, 0);
        axi_write(7'h40, 32'h11, 4'hF, 0, 0, 0, 0, 0);
        axi_read(7'h40, 0);
        axi_read(7'h0C, 0);
        axi_write(7'h00, 32'h3, 4'hF, 0, 0, 0, 0, 0);
        check_side();

        awaddr = 7'h48; wdata = 32'h7777_7777; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; t = 0;
        while (!bvalid && t < 10) begin
            @(negedge clk); aw_f = awvalid && awready; w_f = wvalid && wready;
            @(posedge clk); #1;
            if (aw_f) awvalid = 0;
            if (w_f) wvalid = 0;
            t++;
        end
        awvalid = 0; wvalid = 0;
        check("pre_reset_bvalid", 32'(bvalid), 1);
        rst_n = 0;
        #2;
        check("mid_reset_bvalid", 32'(bvalid), 0);
        check("mid_reset_awready", 32'(awready), 0);
        check("mid_reset_ctrl", ctrl_o, 0);
        m_reset();
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        foreach (addrs[k]) axi_read(addrs[k], 0);
        check_side();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pu_config_regs.md
Name: pu_config_regs

Overview:
- AXI4-Lite register bank that sits directly upstream of the protection unit's access checker. It holds the CTRL word and the per-region policy words, and drives both as flat vectors into the checker.
- It also captures violation reports coming back from the checker and exposes them as status registers plus an interrupt line.
- It is the block the config master programs at offsets 0x00 (CTRL), 0x04 (STATUS) and 0x40+ (POLICY).

Parameters:
- C_S_AXI_DATA_WIDTH, 32: AXI-Lite data width. Only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 7: byte address width, covering offsets 0x00–0x7F.
- NUM_POLICY, 4: number of policy words, mapped at 0x40 + 4*i. Legal range 1–16.
- ID_WIDTH, 1: width of the violating-master ID.

Ports:
- s00_axi_aclk  in  1  sole clock.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- s00_axi_awaddr  in  7  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  AW handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte strobes.
- s00_axi_wvalid / s00_axi_wready  in / out  1  W handshake.
- s00_axi_bresp  out  2  write response.
- s00_axi_bvalid / s00_axi_bready  out / in  1  B handshake.
- s00_axi_araddr  in  7  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid / s00_axi_arready  in / out  1  AR handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid / s00_axi_rready  out / in  1  R handshake.
- ctrl_o  out  32  CTRL register contents, to the checker.
- policy_o  out  32*NUM_POLICY  policy words; word i is at bits [32i+31:32i].
- viol_i  in  1  single-cycle violation pulse from the checker.
- viol_addr_i  in  32  offending address, valid with viol_i.
- viol_id_i  in  ID_WIDTH  offending master ID, valid with viol_i.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset (async assert, sync release): all ready/valid outputs = 0, bresp/rresp = 0, rdata = 0, all registers = 0, irq_o = 0.
- Register map:
  - 0x00 CTRL: RW, all 32 bits stored. Bit0 = checker enable; bit1 = irq enable.
  - 0x04 STATUS: bit0 = VIOL sticky flag, W1C; bits[15:8] = violation count, saturating at 0xFF; bits[23:16] = first-violation ID, zero-extended. Writing 1 to bit0 clears the flag and the count.
  - 0x08 VADDR: RO, address of the first violation since the last clear.
  - 0x40 + 4i, i < NUM_POLICY: POLICY[i], RW.
  - Any other offset: reads return 0 with SLVERR (2'b10); writes are discarded with SLVERR. Writes to RO registers are ignored with OKAY.
- Write channel FSM with states W_IDLE, W_RESP:
  - AW and W may arrive in either order or together. Each is latched independently; awready/wready are high in W_IDLE while the corresponding latch is empty.
  - Once both are latched, the register update happens in that cycle (wstrb applied per byte) and the FSM moves to W_RESP with bvalid = 1 on the next cycle.
  - bvalid holds until bready, then the FSM returns to W_IDLE.
  - No new AW or W is accepted while in W_RESP.
- Read channel FSM with states R_IDLE, R_DATA:
  - arready = 1 in R_IDLE. On an AR handshake, rdata/rresp are registered and rvalid = 1 on the next cycle.
  - rvalid holds until rready. Read latency from AR handshake to rvalid is 1 cycle.
- Violation capture:
  - On viol_i: count increments with saturation. If VIOL = 0, VADDR and ID are loaded and VIOL is set. Later violations update only the count.
  - If viol_i coincides with a W1C write to STATUS, the violation wins: VIOL = 1, count = 1, VADDR/ID are loaded.
- irq_o is registered: irq_o = VIOL & CTRL[1].
- ctrl_o and policy_o come straight from the registers and change one cycle after the write handshake completes.
- Reset asserted mid-transaction: FSMs return to idle immediately and the in-flight response is dropped.

Optional Feature:
- Macro PU_CFG_LOCK_EN.
- Defined:
  - Adds a LOCK register at 0x0C; bit0 is write-once-to-1 and clears only on reset.
  - While LOCK = 1, writes to CTRL and POLICY are discarded and return SLVERR.
  - LOCK reads back its value.
- Undefined: 0x0C is unmapped (SLVERR), and CTRL/POLICY are always writable.

Test Plan:
- Write 0x00 = 0xF0F0F0F0, then read 0x00 -> rdata 0xF0F0F0F0, OKAY; ctrl_o = 0xF0F0F0F0.
- Write 0x40 = 0x0000002C with wstrb 4'b0001, then read 0x40 -> 0x2C; policy_o[31:0] = 0x2C. Then write 0x40 = 0xFFFFFFFF with wstrb 4'b0100 -> read returns 0x00FF002C.
- Present W three cycles before AW, with bready held low for 5 cycles -> exactly one bvalid, held for the full 5 cycles, and the register is updated once.
- Set CTRL = 0x2. Pulse viol_i with addr 0x4000_1000, id 1, then pulse again with addr 0x5000_0000 -> STATUS = 0x0001_0201, VADDR = 0x4000_1000, irq_o = 1. Write 0x04 = 1 -> STATUS = 0, irq_o = 0 one cycle later.
- Read 0x20 -> rdata 0, SLVERR. Write 0x7C -> SLVERR, with no change to any register.
- With PU_CFG_LOCK_EN: write 0x0C = 1, then write 0x40 = 0x11 -> SLVERR and 0x40 keeps its previous value. Assert s00_axi_aresetn low -> LOCK = 0 and every register reads 0.
